// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the 1-to-8 packet router.
// Holds the controller FSM encoding, lane count, select width, one-hot helper.
package router_pkg;

  localparam int ROUTER_LANES = 8;
  localparam int ROUTER_SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_PARITY  = 2'd3
  } router_st_e;

  function automatic logic [ROUTER_LANES-1:0] lane_onehot(
    input logic [ROUTER_SEL_W-1:0] s
  );
    return ROUTER_LANES'(1) << s;
  endfunction

endpackage

// File: rtl/router_lane_demux.sv
// router_lane_demux: combinational lane steering for the router datapath.
// Ports: sel/en/in_valid in, out_ready[8] in; out_valid[8] one-hot, lane_ready out.
module router_lane_demux
  import router_pkg::*;
(
  input  logic [ROUTER_SEL_W-1:0] sel,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [ROUTER_LANES-1:0] out_ready,
  output logic [ROUTER_LANES-1:0] out_valid,
  output logic                    lane_ready
);

  assign out_valid  = (en && in_valid) ? lane_onehot(sel) : '0;
  assign lane_ready = out_ready[sel];

endmodule

// File: rtl/router_pkt_ctrl.sv
// router_pkt_ctrl: serial header/payload sequencer driving the 1-to-8 demux.
// Ports: clk, rst (sync, active high); in_valid/in_data/in_ready ingress;
//   out_ready[8]/out_valid[8]/out_data egress; sel, busy, pkt_done, par_err.
// Optional trailer parity check: define ROUTER_PKT_PARITY_EN.
module router_pkt_ctrl
  import router_pkg::*;
#(
  parameter int PAYLOAD_LEN = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_data,
  output logic                    in_ready,
  input  logic [ROUTER_LANES-1:0] out_ready,
  output logic [ROUTER_LANES-1:0] out_valid,
  output logic                    out_data,
  output logic [ROUTER_SEL_W-1:0] sel,
  output logic                    busy,
  output logic                    pkt_done,
  output logic                    par_err
);

  localparam int CW = $clog2(PAYLOAD_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(PAYLOAD_LEN - 1);

`ifdef ROUTER_PKT_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  router_st_e state, state_nx;

  logic [1:0]    acnt;
  logic [1:0]    ash;
  logic [CW-1:0] pcnt;
  logic          in_pay;
  logic          lane_ready;
  logic          beat;
  logic          pay_last;
  logic          done_nx;

  // Egress is only live in PAYLOAD, and never while reset is held.
  assign in_pay = (state == ST_PAYLOAD) && !rst;

  router_lane_demux u_demux (
    .sel        (sel),
    .en         (in_pay),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .lane_ready (lane_ready)
  );

  assign out_data = in_pay & in_data;

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (state)
        ST_PAYLOAD: in_ready = lane_ready;
        default:    in_ready = 1'b1;
      endcase
    end
  end

  assign beat     = in_valid && in_ready;
  assign pay_last = (pcnt == LAST);

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    if (beat) begin
      case (state)
        ST_IDLE: state_nx = ST_ADDR;
        ST_ADDR: begin
          if (acnt == 2'd2) state_nx = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          if (pay_last) begin
            state_nx = PAR_EN ? ST_PARITY : ST_IDLE;
            done_nx  = !PAR_EN;
          end
        end
        default: begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      acnt     <= '0;
      ash      <= '0;
      pcnt     <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      pkt_done <= 1'b0;
    end else begin
      state    <= state_nx;
      busy     <= (state_nx != ST_IDLE);
      pkt_done <= done_nx;
      if (beat) begin
        case (state)
          ST_IDLE: begin
            ash  <= {1'b0, in_data};
            acnt <= 2'd1;
          end
          ST_ADDR: begin
            ash  <= {ash[0], in_data};
            acnt <= acnt + 2'd1;
            if (acnt == 2'd2) begin
              sel  <= {ash, in_data};
              acnt <= '0;
              pcnt <= '0;
            end
          end
          ST_PAYLOAD: pcnt <= pcnt + CW'(1);
          default: ;
        endcase
      end
    end
  end

`ifdef ROUTER_PKT_PARITY_EN
  // Running even parity over header and payload; trailer closes it.
  logic par;

  always_ff @(posedge clk) begin
    if (rst) begin
      par     <= 1'b0;
      par_err <= 1'b0;
    end else begin
      par_err <= 1'b0;
      if (beat) begin
        case (state)
          ST_IDLE:   par     <= in_data;
          ST_PARITY: par_err <= par ^ in_data;
          default:   par     <= par ^ in_data;
        endcase
      end
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule
